// File: rtl/adc_qsys_sysid_ext_if.sv
// adc_qsys_sysid_ext_if: Avalon-MM slave bus bundle for the system-ID block
interface adc_qsys_sysid_ext_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/adc_qsys_sysid_ext.sv
// adc_qsys_sysid_ext: system-ID slave with scratch, 64-bit uptime counter and fixed read latency
module adc_qsys_sysid_ext #(
    parameter logic [31:0] ID_VALUE        = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP_VALUE = 32'd1430722590,
    parameter int          READ_LATENCY    = 1,
    parameter logic        CNT_RESET_EN    = 1'b1
) (
    input logic                 clock,
    input logic                 reset_n,
    adc_qsys_sysid_ext_if.slave bus
);
    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    logic [63:0] cnt;
    logic [31:0] shadow;
    logic [31:0] scratch;
    logic [31:0] rd_mux;
    logic        enable;
    logic        wrap_sticky;
    logic        wr_ctl;
    logic        clr;
    logic        wr_sts;
    logic        wr_scr;
    logic        rd_lo;
    logic        wrap;
    logic [31:0] pipe_d [READ_LATENCY];
    logic        pipe_v [READ_LATENCY];

    assign wr_ctl = bus.write && bus.address == 3'd5 && bus.byteenable[0];
    assign clr    = wr_ctl && bus.writedata[1];
    assign wr_sts = bus.write && bus.address == 3'd6 && bus.byteenable[0] && bus.writedata[0];
    assign wr_scr = bus.write && bus.address == 3'd2;
    assign rd_lo  = bus.read && bus.address == 3'd3;
    // a clear in the same cycle suppresses the wrap so no sticky is raised
    assign wrap   = enable && !clr && &cnt;

    // register file view as seen by a read in the accept cycle (pre-write values)
    always_comb begin
        case (bus.address)
            3'd0:    rd_mux = ID_VALUE;
            3'd1:    rd_mux = TIMESTAMP_VALUE;
            3'd2:    rd_mux = scratch;
            3'd3:    rd_mux = cnt[31:0];
            3'd4:    rd_mux = shadow;
            3'd5:    rd_mux = {31'b0, enable};
            3'd6:    rd_mux = {21'b0, LAT, 7'b0, wrap_sticky};
            default: rd_mux = '0;
        endcase
    end

    // counter, shadow, control/status and scratch state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            shadow      <= '0;
            scratch     <= '0;
            enable      <= CNT_RESET_EN;
            wrap_sticky <= 1'b0;
        end else begin
            if (clr)
                cnt <= '0;
            else if (enable)
                cnt <= cnt + 64'd1;
            if (rd_lo)
                shadow <= cnt[63:32];
            if (wr_ctl)
                enable <= bus.writedata[0];
            if (wrap)
                wrap_sticky <= 1'b1;
            else if (wr_sts)
                wrap_sticky <= 1'b0;
            for (int b = 0; b < 4; b++)
                if (wr_scr && bus.byteenable[b])
                    scratch[8*b +: 8] <= bus.writedata[8*b +: 8];
        end
    end

    // fixed-depth response pipeline; data lanes stay zero when no read is in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= bus.read;
            pipe_d[0] <= bus.read ? rd_mux : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign bus.readdata      = pipe_d[READ_LATENCY-1];
    assign bus.readdatavalid = pipe_v[READ_LATENCY-1];
endmodule
